interleaver_pp: RTL and testbench
=================================

INTERLEAVER_PP -- requirements
Module: interleaver_pp

Interface
REQ-001 Parameter BASE_NCBPS, default 192, coded bits per block at s=1; SHALL be a multiple of D.
REQ-002 Parameter D, default 16, interleaver column count.
REQ-003 Derived MAX_NCBPS = 3*BASE_NCBPS; AW = ceil(log2(MAX_NCBPS)).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 mode  input  2  0=QPSK (s=1), 1=16QAM (s=2), 2=64QAM (s=3), 3=reserved, treated as 0.
REQ-007 data_valid  input  1  upstream bit valid.
REQ-008 input_data  input  1  upstream coded bit.
REQ-009 ready_out  output  1  block accepts a bit this cycle.
REQ-010 ready_in  input  1  downstream accepts output_data this cycle.
REQ-011 valid_out  output  1  output_data valid.
REQ-012 output_data  output  1  interleaved bit.
REQ-013 block_done  output  1  one-cycle pulse on acceptance of the last output bit of a block.

Function
REQ-014 Block length Ncbps = s*BASE_NCBPS, s from mode.
REQ-015 Input accepted on edge where data_valid && ready_out; output consumed on edge where valid_out && ready_in.
REQ-016 Two banks of MAX_NCBPS bits (A, B), ping-pong; writer starts on A after reset, then alternates; reader follows same order.
REQ-017 Bank states: EMPTY -> FILLING (first accepted bit) -> FULL (last bit written) -> DRAINING (first bit loaded to output) -> EMPTY (last bit consumed).
REQ-018 mode SHALL be sampled on the first accepted bit of a block and stored with that bank; mode changes mid-block ignored.
REQ-019 Input index k (0..Ncbps-1) written to address j: m = (Ncbps/D)*(k mod D) + floor(k/D); j = s*floor(m/s) + ((m + Ncbps - floor(D*m/Ncbps)) mod s).
REQ-020 All arithmetic exact, unsigned, no truncation below AW+5 bits in intermediates.
REQ-021 Reader emits bank addresses 0..Ncbps-1 in ascending order using the bank's stored mode.
REQ-022 ready_out = 1 iff current write bank is EMPTY or FILLING; 0 when both banks FULL/DRAINING.
REQ-023 Output registered: output_data/valid_out load when (!valid_out || ready_in) and a bank is FULL or DRAINING with bits remaining.
REQ-024 Latency: last input bit accepted at edge T -> bank FULL after T; if output register free, valid_out=1 with bit 0 after edge T+1.
REQ-025 Throughput: with ready_in=1 continuously, one output bit per cycle, no bubble between consecutive blocks when next bank already FULL.
REQ-026 ready_in low holds output_data and valid_out stable.
REQ-027 Drained bank becomes EMPTY on the edge its last bit is consumed; ready_out may rise the following cycle.
REQ-028 Simultaneous write-complete on one bank and drain-complete on the other on the same edge SHALL both take effect.
REQ-029 block_done asserted in cycle after the handshake of bit Ncbps-1.
REQ-030 data_valid while ready_out=0 SHALL be ignored; no bit lost or duplicated when accepted.

Reset
REQ-031 While reset=1: valid_out=0, output_data=0, block_done=0, ready_out=0, both banks EMPTY, counters 0, write and read bank pointers = A.
REQ-032 ready_out=1 first cycle after reset deasserts.
REQ-033 Reset mid-block discards partial and full blocks; bank contents need not be cleared.

Verification
REQ-034 mode=0, 192 bits with only k=1 set, ready_in=1 -> 192 outputs, only position 12 is 1; block_done once.
REQ-035 mode=1, 384 bits with only k=1 set -> only output position 25 is 1; k=0 -> position 0.
REQ-036 mode=2, 576 bits with only k=1 set -> only output position 38 is 1.
REQ-037 Three back-to-back QPSK blocks, ready_in=0 -> ready_out falls after bit 383 accepted; ready_in=1 -> continuous 576 outputs, correct order, ready_out rises after first block drains.
REQ-038 mode toggled 0->2 at k=100 of a QPSK block -> block stays 192 bits; next block is 576 bits.
REQ-039 reset pulsed at output bit 50 -> valid_out=0 immediately, ready_out=1 after release, next block correct from bit 0.

Source files
------------

// File: rtl/interleaver_pp.sv
// Purpose: ping-pong block bit interleaver (two banks, write permuted / read linear).
// Latency: bit 0 of a block is presented the cycle after its last input bit is written.
// Backpressure: ready_out drops while both banks are full/draining; ready_in stalls the output register.
//
// Ports:
//   clk, reset           single rising-edge clock, async active-high reset
//   mode[1:0]            0=QPSK(s=1) 1=16QAM(s=2) 2=64QAM(s=3) 3=treated as QPSK
//   data_valid/input_data/ready_out   upstream bit handshake
//   valid_out/output_data/ready_in    downstream bit handshake
//   block_done           one-cycle pulse after the last bit of a block is consumed
module interleaver_pp #(
    parameter int BASE_NCBPS = 192,
    parameter int D          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       data_valid,
    input  logic       input_data,
    output logic       ready_out,
    input  logic       ready_in,
    output logic       valid_out,
    output logic       output_data,
    output logic       block_done
);

    localparam int MAX_NCBPS = 3 * BASE_NCBPS;
    localparam int AW        = $clog2(MAX_NCBPS);
    localparam int W         = AW + 5;

    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] C2     = W'(2);
    localparam logic [W-1:0] C3     = W'(3);
    localparam logic [W-1:0] BLK    = W'(BASE_NCBPS);
    localparam logic [W-1:0] ROWS   = W'(BASE_NCBPS / D);
    localparam logic [W-1:0] D_LAST = W'(D - 1);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    function automatic logic [W-1:0] s_of(input logic [1:0] md);
        case (md)
            2'd1:    s_of = W'(2);
            2'd2:    s_of = W'(3);
            default: s_of = W'(1);
        endcase
    endfunction

    logic             mem [2][MAX_NCBPS];
    logic [1:0]       bank_st   [2];
    logic [1:0]       bank_mode [2];
    logic             wr_ptr, rd_ptr;
    logic [W-1:0]     wr_cnt, wr_col, wr_row, rd_cnt;
    logic             out_last, out_bank;

    logic             wr_first, wr_en, wr_last;
    logic [1:0]       wr_mode;
    logic [W-1:0]     wr_s, wr_n, m, t;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     rd_n;
    logic             rd_avail, rd_last, consume, load;

    always_comb begin
        wr_first  = (bank_st[wr_ptr] == ST_EMPTY);
        // Mode is taken live only for the first bit; afterwards the bank's copy rules.
        wr_mode   = wr_first ? mode : bank_mode[wr_ptr];
        wr_s      = s_of(wr_mode);
        wr_n      = wr_s * BLK;
        ready_out = !reset && ((bank_st[wr_ptr] == ST_EMPTY) || (bank_st[wr_ptr] == ST_FILLING));
        wr_en     = data_valid && ready_out;
        wr_last   = (wr_cnt == wr_n - ONE);

        // wr_col = k mod D, wr_row = floor(k/D). Since wr_row < Ncbps/D,
        // floor(D*m/Ncbps) collapses to wr_col, and Ncbps is a multiple of s.
        m = wr_row + wr_col * (wr_s * ROWS);
        t = m + wr_n - wr_col;
        case (wr_mode)
            2'd1:    wr_addr = AW'(m - (m % C2) + (t % C2));
            2'd2:    wr_addr = AW'(m - (m % C3) + (t % C3));
            default: wr_addr = AW'(m);
        endcase

        rd_n     = s_of(bank_mode[rd_ptr]) * BLK;
        rd_last  = (rd_cnt == rd_n - ONE);
        // rd_ptr leaves a bank as soon as its last bit is loaded, so a
        // DRAINING bank under rd_ptr always still has bits to send.
        rd_avail = (bank_st[rd_ptr] == ST_FULL) || (bank_st[rd_ptr] == ST_DRAINING);
        consume  = valid_out && ready_in;
        load     = (!valid_out || ready_in) && rd_avail;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr][wr_addr] <= input_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_st[0]   <= ST_EMPTY;
            bank_st[1]   <= ST_EMPTY;
            bank_mode[0] <= 2'd0;
            bank_mode[1] <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_cnt       <= '0;
            wr_col       <= '0;
            wr_row       <= '0;
            rd_cnt       <= '0;
            out_last     <= 1'b0;
            out_bank     <= 1'b0;
            valid_out    <= 1'b0;
            output_data  <= 1'b0;
            block_done   <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_first) begin
                    bank_mode[wr_ptr] <= mode;
                    bank_st[wr_ptr]   <= ST_FILLING;
                end
                if (wr_last) begin
                    bank_st[wr_ptr] <= ST_FULL;
                    wr_ptr          <= !wr_ptr;
                    wr_cnt          <= '0;
                    wr_col          <= '0;
                    wr_row          <= '0;
                end else begin
                    wr_cnt <= wr_cnt + ONE;
                    if (wr_col == D_LAST) begin
                        wr_col <= '0;
                        wr_row <= wr_row + ONE;
                    end else begin
                        wr_col <= wr_col + ONE;
                    end
                end
            end

            // Drain completion targets out_bank, never the bank being written or loaded.
            block_done <= consume && out_last;
            if (consume && out_last) begin
                bank_st[out_bank] <= ST_EMPTY;
            end

            if (load) begin
                output_data <= mem[rd_ptr][rd_cnt[AW-1:0]];
                valid_out   <= 1'b1;
                out_bank    <= rd_ptr;
                out_last    <= rd_last;
                if (rd_cnt == '0) begin
                    bank_st[rd_ptr] <= ST_DRAINING;
                end
                if (rd_last) begin
                    rd_cnt <= '0;
                    rd_ptr <= !rd_ptr;
                end else begin
                    rd_cnt <= rd_cnt + ONE;
                end
            end else if (consume) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interleaver_pp.sv
// Purpose: directed scoreboard bench for interleaver_pp (permutation, flow control, reset).
// Latency: expected bits are queued when a block's last input bit is accepted, popped on each output handshake.
// Backpressure: bench drives ready_in per step; every wait is bounded by a cycle budget.
module tb_interleaver_pp;

    localparam int BASE = 192;
    localparam int DC   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       data_valid, input_data, ready_in;
    logic       ready_out, valid_out, output_data, block_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic exp_q[$];
    int   len_q[$];
    logic mdl_blk [576];
    int   mdl_cnt = 0, mdl_mode = 0;
    int   out_pos = 0, hs_cnt = 0, ones = 0, one_pos = -1, pulses = 0;
    int   gap_cnt = 0, gap_snap = -1, snap_at = -1, first_acc_hs = 0;
    logic done_exp = 1'b0;

    interleaver_pp #(.BASE_NCBPS(BASE), .D(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .data_valid (data_valid),
        .input_data (input_data),
        .ready_out  (ready_out),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .output_data(output_data),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Literal form of the interleaver address equation.
    function automatic int perm(input int k, input int s, input int n);
        int m;
        m = (n / DC) * (k % DC) + k / DC;
        return s * (m / s) + ((m + n - (DC * m) / n) % s);
    endfunction

    // One clock: called at the falling edge, drives inputs, scores the
    // handshakes that happen on the next rising edge, returns at the next falling edge.
    task automatic step(input logic dv, input logic din, input logic rin, output logic acc);
        logic hs;
        logic e;
        logic tmp [576];
        int   n;
        data_valid = dv;
        input_data = din;
        ready_in   = rin;
        chk("block_done", block_done, done_exp);
        if (block_done === 1'b1) pulses++;
        done_exp = 1'b0;
        acc = dv && ready_out;
        hs  = valid_out && rin;
        if (rin && !valid_out) gap_cnt++;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", valid_out, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit", output_data, e);
                if (output_data === 1'b1) begin
                    ones++;
                    one_pos = out_pos;
                end
                out_pos++;
                hs_cnt++;
                if (hs_cnt == snap_at) gap_snap = gap_cnt;
                if (out_pos == len_q[0]) begin
                    void'(len_q.pop_front());
                    out_pos  = 0;
                    done_exp = 1'b1;
                end
            end
        end
        if (acc) begin
            if (mdl_cnt == 0) mdl_mode = (mode == 2'd3) ? 0 : int'(mode);
            mdl_blk[mdl_cnt] = din;
            mdl_cnt++;
            n = (mdl_mode + 1) * BASE;
            if (mdl_cnt == n) begin
                for (int k = 0; k < n; k++) tmp[perm(k, mdl_mode + 1, n)] = mdl_blk[k];
                for (int k = 0; k < n; k++) exp_q.push_back(tmp[k]);
                len_q.push_back(n);
                mdl_cnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // one_k < 0 selects random data; otherwise only bit one_k is 1.
    task automatic send_block(input int md, input int n, input int one_k, input logic rin,
                              input int tog_k, input int tog_md);
        logic acc;
        logic b;
        int   budget;
        mode = 2'(md);
        for (int k = 0; k < n; k++) begin
            if (k == tog_k) mode = 2'(tog_md);
            b = (one_k < 0) ? 1'($urandom_range(0, 1)) : (k == one_k);
            budget = 2000;
            acc    = 1'b0;
            while (!acc && budget > 0) begin
                step(1'b1, b, rin, acc);
                budget--;
            end
            if (!acc) begin
                chk("send_timeout", k, n);
                return;
            end
            if (k == 0) first_acc_hs = hs_cnt;
        end
    endtask

    task automatic drain(input int target, input logic tail);
        logic acc;
        int   budget;
        budget = 5000;
        while (hs_cnt < target && budget > 0) begin
            step(1'b0, 1'b0, 1'b1, acc);
            budget--;
        end
        chk("drain_count", hs_cnt, target);
        if (tail) step(1'b0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        int h, p0;
        reset = 1'b1; mode = 2'd0; data_valid = 1'b0; input_data = 1'b0; ready_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_output_data", output_data, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_ready_out", ready_out, 0);
        reset = 1'b0;
        #1;
        chk("ready_out_after_rst", ready_out, 1);

        // QPSK single one at k=1
        ones = 0; one_pos = -1; p0 = pulses;
        send_block(0, 192, 1, 1'b1, -1, 0);
        drain(hs_cnt + 192, 1'b1);
        chk("qpsk_ones", ones, 1);
        chk("qpsk_pos", one_pos, 12);
        chk("qpsk_pulses", pulses - p0, 1);

        // 16QAM k=1 then k=0
        ones = 0; one_pos = -1;
        send_block(1, 384, 1, 1'b1, -1, 0);
        drain(hs_cnt + 384, 1'b1);
        chk("qam16_k1_ones", ones, 1);
        chk("qam16_k1_pos", one_pos, 25);
        ones = 0; one_pos = -1;
        send_block(1, 384, 0, 1'b1, -1, 0);
        drain(hs_cnt + 384, 1'b1);
        chk("qam16_k0_ones", ones, 1);
        chk("qam16_k0_pos", one_pos, 0);

        // 64QAM k=1
        ones = 0; one_pos = -1;
        send_block(2, 576, 1, 1'b1, -1, 0);
        drain(hs_cnt + 576, 1'b1);
        chk("qam64_ones", ones, 1);
        chk("qam64_pos", one_pos, 38);

        // Three back-to-back QPSK blocks, downstream stalled for the first two
        h = hs_cnt;
        send_block(0, 192, -1, 1'b0, -1, 0);
        send_block(0, 192, -1, 1'b0, -1, 0);
        chk("ready_out_both_full", ready_out, 0);
        chk("stalled_valid_out", valid_out, 1);
        gap_cnt = 0; gap_snap = -1; snap_at = h + 384;
        send_block(0, 192, -1, 1'b1, -1, 0);
        chk("ready_out_rise_hs", first_acc_hs - h, 193);
        drain(h + 576, 1'b1);
        chk("no_bubble_first_384", gap_snap, 0);

        // Mode change mid-block is ignored; next block takes the new mode
        p0 = pulses;
        send_block(0, 192, -1, 1'b1, 100, 2);
        send_block(2, 576, -1, 1'b1, -1, 0);
        drain(hs_cnt + (exp_q.size()), 1'b1);
        chk("toggle_pulses", pulses - p0, 2);

        // Reset while output bit 50 is presented
        h = hs_cnt;
        send_block(0, 192, -1, 1'b0, -1, 0);
        drain(h + 50, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_output_data", output_data, 0);
        chk("midrst_ready_out", ready_out, 0);
        chk("midrst_block_done", block_done, 0);
        exp_q.delete(); len_q.delete();
        mdl_cnt = 0; out_pos = 0; done_exp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hold_valid", valid_out, 0);
        reset = 1'b0;
        #1;
        chk("ready_out_after_midrst", ready_out, 1);
        ones = 0; one_pos = -1;
        send_block(1, 384, 5, 1'b1, -1, 0);
        drain(hs_cnt + 384, 1'b1);
        chk("post_rst_ones", ones, 1);
        chk("post_rst_pos", one_pos, 121);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
